// File: rtl/timer_capture_unit_pkg.sv
// Shared definitions for the capture and alarm channel blocks: default sizes,
// channel-index width and packed-counter slice helpers.
package timer_capture_unit_pkg;

  localparam int TIMER_BITWIDTH_DEF = 32;
  localparam int NB_CAPTURES_DEF    = 10;

  // Channel-index width; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low bit of channel ch inside a packed vector of w-bit lanes.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/timer_capture_unit_round_robin_arbiter.sv
// Round-robin arbiter: searches from the channel after the last grant and only
// moves its pointer when the caller commits the grant with advance.
module round_robin_arbiter
  import timer_capture_unit_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = ch_width(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] last_grant;
  logic [W-1:0] cand_idx;
  logic         found;
  int           cand;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = 0;
    cand_idx     = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(last_grant) + k) % N;
      cand_idx = W'(cand);
      if (!found && req[cand_idx]) begin
        found                  = 1'b1;
        grant_idx              = cand_idx;
        grant_onehot[cand_idx] = 1'b1;
      end
    end
  end

  // Reset points at the last channel so channel 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= W'(N - 1);
    end else if (advance && found) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/timer_capture_unit.sv
// Input-capture unit: per-channel rising-edge capture of the channel counter into
// a one-deep holding register, drained round-robin through a valid/ready port.
module timer_capture_unit
  import timer_capture_unit_pkg::*;
#(
  parameter  int TIMER_BITWIDTH = TIMER_BITWIDTH_DEF,
  parameter  int NB_CAPTURES    = NB_CAPTURES_DEF,
  localparam int CH_W           = ch_width(NB_CAPTURES)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NB_CAPTURES-1:0]              capture_en_i,
  input  logic [NB_CAPTURES-1:0]              event_i,
  input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] counter_i,
  output logic                                cap_valid_o,
  input  logic                                cap_ready_i,
  output logic [CH_W-1:0]                     cap_channel_o,
  output logic [TIMER_BITWIDTH-1:0]           cap_value_o,
  output logic [NB_CAPTURES-1:0]              overflow_o,
  input  logic [NB_CAPTURES-1:0]              overflow_clr_i
);

  logic [NB_CAPTURES-1:0]    evt_q;
  logic [NB_CAPTURES-1:0]    pending;
  logic [NB_CAPTURES-1:0]    cap_evt;
  logic [NB_CAPTURES-1:0]    grant_onehot;
  logic [NB_CAPTURES-1:0]    grant_clr;
  logic [NB_CAPTURES-1:0]    lost;
  logic [NB_CAPTURES-1:0]    accept;
  logic [CH_W-1:0]           grant_idx;
  logic [TIMER_BITWIDTH-1:0] hold [NB_CAPTURES];
  logic                      out_free;
  logic                      do_grant;

  assign cap_evt   = event_i & ~evt_q & capture_en_i;
  assign out_free  = !cap_valid_o || cap_ready_i;
  assign do_grant  = out_free && (|pending);
  assign grant_clr = do_grant ? grant_onehot : '0;
  // A slot being drained this cycle can take a new capture; otherwise first capture wins.
  assign lost      = cap_evt & pending & ~grant_clr;
  assign accept    = cap_evt & ~lost;

  round_robin_arbiter #(
    .N (NB_CAPTURES)
  ) u_arbiter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req          (pending),
    .advance      (do_grant),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_q         <= event_i;
      pending       <= '0;
      overflow_o    <= '0;
      cap_valid_o   <= 1'b0;
      cap_channel_o <= '0;
      cap_value_o   <= '0;
      for (int i = 0; i < NB_CAPTURES; i++) begin
        hold[i] <= '0;
      end
    end else begin
      evt_q      <= event_i;
      pending    <= (pending & ~grant_clr) | accept;
      overflow_o <= (overflow_o & ~overflow_clr_i) | lost;
      for (int i = 0; i < NB_CAPTURES; i++) begin
        if (accept[i]) begin
          hold[i] <= counter_i[slice_lo(i, TIMER_BITWIDTH) +: TIMER_BITWIDTH];
        end
      end
      if (do_grant) begin
        cap_valid_o   <= 1'b1;
        cap_channel_o <= grant_idx;
        cap_value_o   <= hold[grant_idx];
      end else if (out_free) begin
        cap_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_capture_unit.sv
// Bench for timer_capture_unit (4 channels): directed scenarios plus random
// traffic against a capture-queue reference model.
module tb_timer_capture_unit;

  localparam int NB = 4;
  localparam int TB = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NB-1:0]     capture_en_i;
  logic [NB-1:0]     event_i;
  logic [TB*NB-1:0]  counter_i;
  logic              cap_valid_o;
  logic              cap_ready_i;
  logic [1:0]        cap_channel_o;
  logic [TB-1:0]     cap_value_o;
  logic [NB-1:0]     overflow_o;
  logic [NB-1:0]     overflow_clr_i;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_pend [NB];
  logic [31:0] m_hold [NB];
  bit          m_valid;
  int          m_ch;
  logic [31:0] m_val;
  int          m_last;
  logic [NB-1:0] m_ovf;
  logic [NB-1:0] m_evt;

  timer_capture_unit #(
    .TIMER_BITWIDTH (TB),
    .NB_CAPTURES    (NB)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .capture_en_i   (capture_en_i),
    .event_i        (event_i),
    .counter_i      (counter_i),
    .cap_valid_o    (cap_valid_o),
    .cap_ready_i    (cap_ready_i),
    .cap_channel_o  (cap_channel_o),
    .cap_value_o    (cap_value_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance the model by one clock from the current inputs.
  task automatic model_step();
    bit consume;
    int g;
    int c;
    if (rst_i) begin
      for (int i = 0; i < NB; i++) begin
        m_pend[i] = 0;
        m_hold[i] = '0;
      end
      m_valid = 0; m_ch = 0; m_val = '0; m_last = NB - 1; m_ovf = '0;
      m_evt = event_i;
      return;
    end
    consume = !m_valid || cap_ready_i;
    g = -1;
    if (consume) begin
      for (int k = 1; k <= NB; k++) begin
        c = (m_last + k) % NB;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      m_valid = 1; m_ch = g; m_val = m_hold[g]; m_last = g; m_pend[g] = 0;
    end else if (consume) begin
      m_valid = 0;
    end
    m_ovf = m_ovf & ~overflow_clr_i;
    for (int i = 0; i < NB; i++) begin
      if (event_i[i] && !m_evt[i] && capture_en_i[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1;
          m_hold[i] = counter_i[i*TB +: TB];
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
    m_evt = event_i;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cnt(input int ch, input logic [31:0] v);
    counter_i[ch*TB +: TB] = v;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; event_i = '0; overflow_clr_i = '0;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", cap_valid_o); end
    total++; if (cap_channel_o !== 2'd0) begin bad++; $display("FAIL reset_channel got=%0d want=0", cap_channel_o); end
    total++; if (cap_value_o !== 32'h0) begin bad++; $display("FAIL reset_value got=%h want=0", cap_value_o); end
    total++; if (overflow_o !== 4'h0) begin bad++; $display("FAIL reset_overflow got=%b want=0000", overflow_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    cap_ready_i = 1'b1;
    set_cnt(2, 32'h0000_1234);
    event_i[2] = 1'b1;
    tick();
    total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL single_early got=%0b want=0", cap_valid_o); end
    event_i[2] = 1'b0;
    set_cnt(2, 32'hDEAD_0000);
    tick();
    total++; if (cap_valid_o !== 1'b1 || cap_channel_o !== 2'd2 || cap_value_o !== 32'h1234) begin
      bad++; $display("FAIL single_record got=%0b/%0d/%h want=1/2/00001234", cap_valid_o, cap_channel_o, cap_value_o);
    end
    tick();
    total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL single_drop got=%0b want=0", cap_valid_o); end
  endtask

  task automatic test_simultaneous();
    logic [1:0]  exp_ch  [3];
    logic [31:0] exp_val [3];
    exp_ch[0] = 2'd0; exp_val[0] = 32'h10;
    exp_ch[1] = 2'd1; exp_val[1] = 32'h20;
    exp_ch[2] = 2'd3; exp_val[2] = 32'h30;
    do_reset();
    cap_ready_i = 1'b1;
    set_cnt(0, 32'h10); set_cnt(1, 32'h20); set_cnt(2, 32'h99); set_cnt(3, 32'h30);
    event_i = 4'b1011;
    tick();
    event_i = '0;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++; if (cap_valid_o !== 1'b1 || cap_channel_o !== exp_ch[n] || cap_value_o !== exp_val[n]) begin
        bad++; $display("FAIL simult_rec%0d got=%0b/%0d/%h want=1/%0d/%h", n, cap_valid_o, cap_channel_o, cap_value_o, exp_ch[n], exp_val[n]);
      end
    end
    tick();
    total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL simult_end got=%0b want=0", cap_valid_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cap_ready_i = 1'b0;
    set_cnt(1, 32'hA1); set_cnt(2, 32'hA2);
    event_i = 4'b0110;
    tick();
    event_i = '0;
    tick();
    for (int n = 0; n < 5; n++) begin
      set_cnt(1, $urandom); set_cnt(2, $urandom);
      tick();
      total++; if (cap_valid_o !== 1'b1 || cap_channel_o !== 2'd1 || cap_value_o !== 32'hA1) begin
        bad++; $display("FAIL bp_hold%0d got=%0b/%0d/%h want=1/1/000000a1", n, cap_valid_o, cap_channel_o, cap_value_o);
      end
    end
    cap_ready_i = 1'b1;
    tick();
    total++; if (cap_valid_o !== 1'b1 || cap_channel_o !== 2'd2 || cap_value_o !== 32'hA2) begin
      bad++; $display("FAIL bp_next got=%0b/%0d/%h want=1/2/000000a2", cap_valid_o, cap_channel_o, cap_value_o);
    end
    tick();
    total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL bp_end got=%0b want=0", cap_valid_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    cap_ready_i = 1'b0;
    set_cnt(0, 32'h50);
    event_i = 4'b0001; tick();
    event_i = '0;      tick();
    set_cnt(1, 32'h100);
    event_i = 4'b0010; tick();
    event_i = '0;      tick();
    set_cnt(1, 32'h200);
    event_i = 4'b0010; tick();
    total++; if (overflow_o[1] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow_o[1]); end
    event_i = '0;
    cap_ready_i = 1'b1;
    tick();
    total++; if (cap_valid_o !== 1'b1 || cap_channel_o !== 2'd1 || cap_value_o !== 32'h100) begin
      bad++; $display("FAIL ovf_first_wins got=%0b/%0d/%h want=1/1/00000100", cap_valid_o, cap_channel_o, cap_value_o);
    end
    tick();
    total++; if (cap_valid_o !== 1'b0 || overflow_o !== 4'b0010) begin
      bad++; $display("FAIL ovf_sticky got=%0b/%b want=0/0010", cap_valid_o, overflow_o);
    end
    overflow_clr_i = 4'b0010; tick();
    overflow_clr_i = '0;
    total++; if (overflow_o[1] !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow_o[1]); end
    cap_ready_i = 1'b0;
    set_cnt(0, 32'h60);
    event_i = 4'b0001; tick();
    event_i = '0;      tick();
    event_i = 4'b0010; tick();
    event_i = '0;      tick();
    event_i = 4'b0010; overflow_clr_i = 4'b0010; tick();
    total++; if (overflow_o[1] !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b want=1", overflow_o[1]); end
    event_i = '0; overflow_clr_i = '0; cap_ready_i = 1'b1;
    tick(); tick(); tick();
    overflow_clr_i = 4'b0010; tick();
    overflow_clr_i = '0;
  endtask

  task automatic test_enable_reset();
    do_reset();
    cap_ready_i = 1'b1;
    capture_en_i = 4'b1110;
    event_i = 4'b0001; tick();
    event_i = '0;
    for (int n = 0; n < 2; n++) begin
      tick();
      total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL en_block%0d got=%0b want=0", n, cap_valid_o); end
    end
    capture_en_i = 4'hF;
    rst_i = 1'b1; event_i = 4'b0001;
    tick(); tick();
    rst_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL rst_high_evt%0d got=%0b want=0", n, cap_valid_o); end
    end
    event_i = '0; tick();
    cap_ready_i = 1'b0;
    event_i = 4'b0110; tick();
    event_i = '0;      tick();
    total++; if (cap_valid_o !== 1'b1 || cap_channel_o !== 2'd1) begin
      bad++; $display("FAIL rst_pre got=%0b/%0d want=1/1", cap_valid_o, cap_channel_o);
    end
    rst_i = 1'b1; tick();
    total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0b want=0", cap_valid_o); end
    rst_i = 1'b0; cap_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      total++; if (cap_valid_o !== 1'b0) begin bad++; $display("FAIL rst_stale%0d got=%0b want=0", n, cap_valid_o); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst_i          = ($urandom_range(0, 149) == 0);
      event_i        = 4'($urandom);
      capture_en_i   = 4'($urandom) | 4'($urandom);
      cap_ready_i    = ($urandom_range(0, 3) != 0);
      overflow_clr_i = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      for (int i = 0; i < NB; i++) set_cnt(i, $urandom);
      tick();
      total++; if (cap_valid_o !== m_valid) begin
        bad++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", n, cap_valid_o, m_valid);
      end
      if (m_valid) begin
        total++; if (cap_channel_o !== 2'(m_ch) || cap_value_o !== m_val) begin
          bad++; $display("FAIL rand_record cyc=%0d got=%0d/%h want=%0d/%h", n, cap_channel_o, cap_value_o, m_ch, m_val);
        end
      end
      total++; if (overflow_o !== m_ovf) begin
        bad++; $display("FAIL rand_overflow cyc=%0d got=%b want=%b", n, overflow_o, m_ovf);
      end
    end
    rst_i = 1'b0; event_i = '0; overflow_clr_i = '0;
  endtask

  initial begin
    rst_i          = 1'b1;
    capture_en_i   = 4'hF;
    event_i        = '0;
    counter_i      = '0;
    cap_ready_i    = 1'b1;
    overflow_clr_i = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_enable_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
